// File: rtl/lane_traffic_engine.sv
// Lane traffic game logic: six wrapping car lanes, collision/goal detection,
// score, lives and speed level, driven by a level-scaled step tick.

module lane_car #(
  parameter logic [3:0] INIT = 4'd0,
  parameter bit         DEC  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  output logic [3:0] x_o
);
  logic [3:0] x_q, x_d;

  always_comb begin
    x_d = x_q;
    if (load_i)      x_d = INIT;
    else if (step_i) x_d = DEC ? x_q - 4'd1 : x_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) x_q <= INIT;
    else      x_q <= x_d;

  assign x_o = x_q;
endmodule

module lane_traffic_engine #(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned HIT_HOLD    = 2,
  parameter int unsigned START_LIVES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  player_x,
  input  logic [3:0]  player_y,
  output logic [23:0] car_x,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [1:0]  level,
  output logic        hit,
  output logic        goal,
  output logic        respawn,
  output logic        game_over
);
  localparam int NUM_LANES = 6;
  localparam int VEC_W     = 4;
  localparam int CNT_W     = $clog2(TICK_DIV + 1);
  localparam int HOLD_W    = (HIT_HOLD < 2) ? 1 : $clog2(HIT_HOLD + 1);

  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_e;

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d, period_m1;
  logic [HOLD_W-1:0]                  hold_q, hold_d;
  logic [7:0]                         score_q, score_d, score_new;
  logic [1:0]                         lives_q, lives_d, level_q, level_d;
  logic                               hit_q, hit_d, goal_q, goal_d, resp_q, resp_d;
  logic                               on_car_q, ynz_q;
  logic                               run, step_en, on_car, coll, goal_c;
  logic                               car_load, car_step;
  logic [2:0]                         lane_sel;
  logic [NUM_LANES-1:0][VEC_W-1:0]    car_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_car #(
      .INIT (VEC_W'(3 * i)),
      .DEC  ((i % 2) == 1)
    ) u_car (
      .clk    (clk),
      .rst    (rst),
      .load_i (car_load),
      .step_i (car_step),
      .x_o    (car_q[i])
    );
  end

  // >= rather than == so a level-up that shrinks the period below the
  // current count fires on the next cycle instead of running the counter out.
  assign period_m1 = CNT_W'((TICK_DIV >> level_q) - 1);
  assign run       = (state_q == PLAY) || (state_q == HIT);
  assign step_en   = run && (cnt_q >= period_m1);

  assign lane_sel  = player_y[2:0] - 3'd1;
  assign on_car    = (player_y >= 4'd1) && (player_y <= 4'd6) && (car_q[lane_sel] == player_x);
  assign coll      = on_car && !on_car_q;
  assign goal_c    = (player_y == 4'd0) && ynz_q;

  assign score_new = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    score_d  = score_q;
    level_d  = level_q;
    hold_d   = hold_q;
    hit_d    = 1'b0;
    goal_d   = 1'b0;
    resp_d   = 1'b0;
    car_load = 1'b0;
    car_step = 1'b0;
    cnt_d    = run ? (step_en ? '0 : cnt_q + 1'b1) : '0;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d  = PLAY;
          lives_d  = 2'(START_LIVES);
          score_d  = '0;
          level_d  = '0;
          car_load = 1'b1;
          resp_d   = 1'b1;
        end
      end
      PLAY: begin
        if (coll) begin
          state_d = HIT;
          lives_d = lives_q - 2'd1;
          hold_d  = '0;
          hit_d   = 1'b1;
          resp_d  = 1'b1;
        end else begin
          car_step = step_en;
          if (goal_c) begin
            goal_d  = 1'b1;
            resp_d  = 1'b1;
            score_d = score_new;
            level_d = score_new[3:2] | ((score_new >= 8'd12) ? 2'd3 : 2'd0);
          end
        end
      end
      HIT: begin
        if (step_en) begin
          if (hold_q == HOLD_W'(HIT_HOLD - 1)) begin
            hold_d  = '0;
            state_d = (lives_q == 2'd0) ? OVER : PLAY;
          end else begin
            hold_d  = hold_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      score_q  <= '0;
      lives_q  <= 2'(START_LIVES);
      level_q  <= '0;
      hit_q    <= 1'b0;
      goal_q   <= 1'b0;
      resp_q   <= 1'b0;
      on_car_q <= 1'b0;
      ynz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      level_q  <= level_d;
      hit_q    <= hit_d;
      goal_q   <= goal_d;
      resp_q   <= resp_d;
      on_car_q <= on_car;
      ynz_q    <= (player_y != 4'd0);
    end
  end

  assign car_x     = car_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign level     = level_q;
  assign hit       = hit_q;
  assign goal      = goal_q;
  assign respawn   = resp_q;
  assign game_over = (state_q == OVER);
endmodule
